// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stream path: default widths/depths
// and a constant-evaluable ceiling-log2 used to size pointers and counters.
package fir_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_out_fifo_mem.sv
// Storage array for fir_out_fifo: pDEPTH entries of {tlast, tdata},
// synchronous write port and asynchronous (combinational) read port.
module fir_out_fifo_mem
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
  parameter int pDEPTH      = FIFO_DEPTH_DEF,
  localparam int AW         = clog2(pDEPTH)
) (
  input  logic                   axis_clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [pDATA_WIDTH:0]   wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [pDATA_WIDTH:0]   rd_data
);

  logic [pDATA_WIDTH:0] storage [pDEPTH];

  // NOTE: the array is deliberately not reset; validity is tracked by the
  // pointers, so clearing entries would only cost a wide reset tree.
  always_ff @(posedge axis_clk) begin
    if (wr_en) storage[wr_addr] <= wr_data;
  end

  assign rd_data = storage[rd_addr];

endmodule

// File: rtl/fir_out_fifo.sv
// First-word-fall-through AXI-Stream FIFO behind the FIR output port.
// Define FIR_OUT_FIFO_HWM_EN to enable occupancy high-water-mark tracking on hwm.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
  parameter int pDEPTH      = FIFO_DEPTH_DEF,
  localparam int AW         = clog2(pDEPTH),
  localparam int PW         = AW + 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [PW-1:0]          level,
  output logic                   pkt_done,
  output logic [PW-1:0]          hwm
);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [pDATA_WIDTH:0] rd_data;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign level    = wr_ptr - rd_ptr;
  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  // Output is gated so nothing stale is shown while empty or in reset.
  assign m_tdata  = m_tvalid ? rd_data[pDATA_WIDTH-1:0] : '0;
  assign m_tlast  = m_tvalid && rd_data[pDATA_WIDTH];

  fir_out_fifo_mem #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_mem (
    .axis_clk (axis_clk),
    .wr_en    (push),
    .wr_addr  (wr_ptr[AW-1:0]),
    .wr_data  ({s_tlast, s_tdata}),
    .rd_addr  (rd_ptr[AW-1:0]),
    .rd_data  (rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      pkt_done <= pop && rd_data[pDATA_WIDTH];
    end
  end

`ifdef FIR_OUT_FIFO_HWM_EN
  logic [PW-1:0] level_next;
  logic [PW-1:0] hwm_q;

  assign level_next = level + PW'(push) - PW'(pop);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      hwm_q <= '0;
    end else if (level_next > hwm_q) begin
      hwm_q <= level_next;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed self-checking bench for fir_out_fifo: a queue scoreboard tracks
// every accepted beat and is compared against the DUT on each clock step.
module tb_fir_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [PW-1:0] level;
  logic          pkt_done;
  logic [PW-1:0] hwm;

  int tests = 0;
  int fails = 0;
  int pkt_count = 0;
  int max_level = 0;
  int push_count = 0;
  logic [DW:0] sb [$];

  fir_out_fifo #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH)
  ) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .level      (level),
    .pkt_done   (pkt_done),
    .hwm        (hwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: predict the handshake from pre-edge signals, advance the
  // scoreboard, then compare all flow-control outputs just after the edge.
  task automatic step();
    logic        do_push;
    logic        do_pop;
    logic        exp_done;
    logic [DW:0] head;
    do_push  = s_tvalid && s_tready;
    do_pop   = m_tvalid && m_tready;
    exp_done = 1'b0;
    if (do_pop) begin
      if (sb.size() == 0) begin
        check("m_tvalid_while_empty", m_tvalid, 0);
      end else begin
        head = sb.pop_front();
        check("fifo_head", {m_tlast, m_tdata}, head);
        exp_done = head[DW];
      end
    end
    if (do_push) begin
      sb.push_back({s_tlast, s_tdata});
      push_count++;
    end
    @(posedge clk);
    #1;
    check("level", level, sb.size());
    check("m_tvalid", m_tvalid, sb.size() != 0);
    check("s_tready", s_tready, sb.size() != DEPTH);
    check("pkt_done", pkt_done, exp_done);
    if (pkt_done) pkt_count++;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_hwm", hwm, 0);
    check("rst_s_tready", s_tready, 1);
    sb.delete();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] data, input logic last, input logic ready);
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    m_tready = ready;
    step();
  endtask

  task automatic drain(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #2;
    apply_reset();

    // Streaming pass-through: 600 beats, tlast on the final one.
    max_level = 0;
    pkt_count = 0;
    for (int i = 0; i < 600; i++) begin
      push_beat(DW'(i * 7 - 300), i == 599, 1'b1);
    end
    drain(1);
    check("stream_max_level", max_level, 1);
    check("stream_pkt_count", pkt_count, 1);
    check("stream_empty", level, 0);

    // Overfill: 20 offered with the sink stalled, only 16 accepted.
    push_count = 0;
    for (int i = 1; i <= 20; i++) begin
      push_beat(DW'(i), 1'b0, 1'b0);
    end
    check("full_accepted", push_count, 16);
    check("full_level", level, 16);
    check("full_s_tready", s_tready, 0);
    check("full_head", m_tdata, 1);
    drain(16);
    check("full_drained", level, 0);

    // Steady push+pop at level 8 across the pointer wrap.
    for (int i = 0; i < 8; i++) push_beat(DW'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_beat(DW'(200 + i), 1'b0, 1'b1);
      check("steady_level", level, 8);
    end
    drain(8);

    // Stall with a negative sample held on the output.
    push_beat(DW'(-10), 1'b0, 1'b0);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", m_tdata, 64'h0000_0000_FFFF_FFF6);
    end
    drain(1);

    // Reset with five entries queued.
    for (int i = 0; i < 5; i++) push_beat(DW'(50 + i), 1'b0, 1'b0);
    check("pre_rst_level", level, 5);
    apply_reset();
    check("post_rst_level", level, 0);
    push_beat(DW'(23), 1'b1, 1'b0);
    check("post_rst_first", m_tdata, 23);
    check("post_rst_last", m_tlast, 1);
    drain(1);

    // High-water mark: fill to 12 then drain.
    apply_reset();
    for (int i = 0; i < 12; i++) push_beat(DW'(300 + i), 1'b0, 1'b0);
    drain(12);
`ifdef FIR_OUT_FIFO_HWM_EN
    check("hwm", hwm, 12);
`else
    check("hwm", hwm, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
